mouse_master_sm: RTL and testbench

MOUSE_MASTER_SM -- requirements
Module: mouse_master_sm

---
 rtl/mouse_pkg.sv | 42 ++++
 rtl/mouse_timeout_counter.sv | 38 +++
 rtl/mouse_master_sm.sv | 133 +++++++++++++
 tb/tb_mouse_master_sm.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// mouse_pkg: shared definitions for the PS/2 mouse host controller.
//   state_t   - master FSM state encoding (also exported on MASTER_STATE)
//   CMD_*     - command bytes sent to the mouse
//   RSP_*     - response bytes expected during bring-up
//   rsp_next  - next-state helper for states that wait on a response byte
package mouse_pkg;

  typedef enum logic [3:0] {
    INIT          = 4'd0,
    SEND_RST      = 4'd1,
    WAIT_SENT_RST = 4'd2,
    WAIT_ACK1     = 4'd3,
    WAIT_BAT      = 4'd4,
    WAIT_ID       = 4'd5,
    SEND_EN       = 4'd6,
    WAIT_SENT_EN  = 4'd7,
    WAIT_ACK2     = 4'd8,
    PKT0          = 4'd9,
    PKT1          = 4'd10,
    PKT2          = 4'd11,
    PUBLISH       = 4'd12
  } state_t;

  localparam int CNT_W = 32;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_ENABLE    = 8'hF4;
  localparam logic [7:0] RSP_ACK       = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK    = 8'hAA;
  localparam logic [7:0] RSP_DEVICE_ID = 8'h00;

  // A received byte decides the outcome (advance on a clean match, else
  // restart); only with no byte this cycle can the timeout restart us.
  function automatic state_t rsp_next(input state_t cur, input state_t advance,
                                      input logic rx_valid, input logic rx_match,
                                      input logic timed_out);
    if (rx_valid) return rx_match ? advance : INIT;
    if (timed_out) return INIT;
    return cur;
  endfunction

endpackage

// File: rtl/mouse_timeout_counter.sv
// mouse_timeout_counter: saturating cycle counter used both for the
// power-up wait and for per-state timeouts.
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - restart counting from zero (wins over enable)
//   enable    - count this cycle
//   limit     - number of cycles until expiry
//   expired   - high during the limit-th counted cycle and held thereafter
module mouse_timeout_counter
  import mouse_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;

  // Widened by one bit so limit == 0 expires immediately instead of
  // underflowing to "never".
  assign expired = ({1'b0, count_q} + (WIDTH+1)'(1)) >= {1'b0, limit};

  // NOTE: clocked state uses non-blocking assignments so every flop in the
  // design samples values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else if (clear)
      count_q <= '0;
    else if (enable && !expired)
      count_q <= count_q + WIDTH'(1);  // stops at expiry: saturates, never wraps
  end

endmodule

// File: rtl/mouse_master_sm.sv
// mouse_master_sm: PS/2 mouse host sequencer. Resets the mouse (0xFF),
// checks ACK / BAT / ID, enables streaming (0xF4), then assembles 3-byte
// movement packets and publishes each complete packet.
//   CLK, RESET            - clock, asynchronous active-high reset
//   SEND_BYTE/BYTE_TO_SEND- one-cycle command request to the transmitter
//   BYTE_SENT             - transmitter done pulse
//   READ_ENABLE           - receiver enable (low only in INIT)
//   BYTE_READ/BYTE_ERROR_CODE/BYTE_READY - received byte, error, strobe
//   MOUSE_STATUS/DX/DY    - last complete packet
//   SEND_INTERRUPT        - one-cycle pulse while a packet is published
//   MASTER_STATE          - current state, for debug
module mouse_master_sm
  import mouse_pkg::*;
#(
  parameter int INIT_WAIT = 500000,
  parameter int TIMEOUT   = 100000000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [3:0] MASTER_STATE
);

  localparam logic [CNT_W-1:0] INIT_LIMIT    = CNT_W'(INIT_WAIT);
  localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT);

  state_t     state_q, state_d;
  logic       expired, rx_ok;
  logic       ld_status, ld_dx, ld_dy;
  logic [7:0] shadow_status, shadow_dx, shadow_dy;

  assign rx_ok = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);

  // One counter serves every state: it restarts on any state change, and
  // PKT0 never times out so it simply does not count there.
  mouse_timeout_counter #(.WIDTH(CNT_W)) u_timer (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (state_d != state_q),
    .enable  (state_q != PKT0),
    .limit   ((state_q == INIT) ? INIT_LIMIT : TIMEOUT_LIMIT),
    .expired (expired)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= INIT;
    else       state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    ld_status = 1'b0;
    ld_dx     = 1'b0;
    ld_dy     = 1'b0;
    unique case (state_q)
      INIT:          if (expired) state_d = SEND_RST;
      SEND_RST:      state_d = WAIT_SENT_RST;
      // BYTE_SENT is tested first so it beats a same-cycle timeout.
      WAIT_SENT_RST: if (BYTE_SENT) state_d = WAIT_ACK1;
                     else if (expired) state_d = INIT;
      WAIT_ACK1:     state_d = rsp_next(state_q, WAIT_BAT, BYTE_READY,
                                        rx_ok && BYTE_READ == RSP_ACK, expired);
      WAIT_BAT:      state_d = rsp_next(state_q, WAIT_ID, BYTE_READY,
                                        rx_ok && BYTE_READ == RSP_BAT_OK, expired);
      WAIT_ID:       state_d = rsp_next(state_q, SEND_EN, BYTE_READY,
                                        rx_ok && BYTE_READ == RSP_DEVICE_ID, expired);
      SEND_EN:       state_d = WAIT_SENT_EN;
      WAIT_SENT_EN:  if (BYTE_SENT) state_d = WAIT_ACK2;
                     else if (expired) state_d = INIT;
      WAIT_ACK2:     state_d = rsp_next(state_q, PKT0, BYTE_READY,
                                        rx_ok && BYTE_READ == RSP_ACK, expired);
      // Bit 3 is always set in a status byte; anything else is dropped to
      // resynchronise on packet boundaries.
      PKT0: if (rx_ok && BYTE_READ[3]) begin
              ld_status = 1'b1;
              state_d   = PKT1;
            end
      PKT1: if (BYTE_READY) begin
              ld_dx   = rx_ok;
              state_d = rx_ok ? PKT2 : PKT0;
            end else if (expired) state_d = PKT0;
      PKT2: if (BYTE_READY) begin
              ld_dy   = rx_ok;
              state_d = rx_ok ? PUBLISH : PKT0;
            end else if (expired) state_d = PKT0;
      PUBLISH:       state_d = PKT0;
      default:       state_d = INIT;
    endcase
  end

  // Shadows absorb partial packets; the visible registers load only on the
  // edge that ends PUBLISH, so an abandoned packet never reaches them.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      shadow_status <= '0;
      shadow_dx     <= '0;
      shadow_dy     <= '0;
      MOUSE_STATUS  <= '0;
      MOUSE_DX      <= '0;
      MOUSE_DY      <= '0;
    end else begin
      if (ld_status) shadow_status <= BYTE_READ;
      if (ld_dx)     shadow_dx     <= BYTE_READ;
      if (ld_dy)     shadow_dy     <= BYTE_READ;
      if (state_q == PUBLISH) begin
        MOUSE_STATUS <= shadow_status;
        MOUSE_DX     <= shadow_dx;
        MOUSE_DY     <= shadow_dy;
      end
    end
  end

  // Decoded straight from the state register: all zero while RESET holds INIT.
  assign SEND_BYTE      = (state_q == SEND_RST) || (state_q == SEND_EN);
  assign BYTE_TO_SEND   = (state_q == SEND_RST) ? CMD_RESET :
                          (state_q == SEND_EN)  ? CMD_ENABLE : 8'h00;
  assign READ_ENABLE    = (state_q != INIT);
  assign SEND_INTERRUPT = (state_q == PUBLISH);
  assign MASTER_STATE   = state_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// tb_mouse_master_sm: self-checking bench for mouse_master_sm with
// INIT_WAIT=10, TIMEOUT=1000 and a 20 ns clock. Bring-up and corner cases
// are hand-written sequences; packet traffic comes from a vector table.
// Expected packets go into a scoreboard queue as the last byte is driven
// and are compared by a monitor when SEND_INTERRUPT fires.
module tb_mouse_master_sm;
  import mouse_pkg::*;

  localparam int INIT_WAIT = 10;
  localparam int TIMEOUT   = 1000;
  localparam int NV        = 16;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;
  logic       BYTE_READY = 1'b0;
  logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [3:0] MASTER_STATE;

  mouse_master_sm #(.INIT_WAIT(INIT_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .SEND_BYTE       (SEND_BYTE),
    .BYTE_TO_SEND    (BYTE_TO_SEND),
    .BYTE_SENT       (BYTE_SENT),
    .READ_ENABLE     (READ_ENABLE),
    .BYTE_READ       (BYTE_READ),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .BYTE_READY      (BYTE_READY),
    .MOUSE_STATUS    (MOUSE_STATUS),
    .MOUSE_DX        (MOUSE_DX),
    .MOUSE_DY        (MOUSE_DY),
    .SEND_INTERRUPT  (SEND_INTERRUPT),
    .MASTER_STATE    (MASTER_STATE)
  );

  always #10 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
  } pkt_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
    state_t     exp_state;
    logic       push;
    pkt_t       pkt;
  } vec_t;

  vec_t vecs[NV];
  pkt_t sb_q[$];
  pkt_t mon_pkt;
  pkt_t last_pkt;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   irq_count = 0;
  int   n_pushed  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Receiver model: one-cycle BYTE_READY pulse; returns at the sample
  // point right after the capturing edge.
  task automatic rx_byte(input logic [7:0] d, input logic [1:0] e);
    @(negedge CLK);
    BYTE_READ       = d;
    BYTE_ERROR_CODE = e;
    BYTE_READY      = 1'b1;
    tick();
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  // Transmitter model: completion pulse after 'delay' cycles.
  task automatic tx_done(input int delay);
    repeat (delay) @(negedge CLK);
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
  endtask

  // Counts sample points until SEND_BYTE is seen (bounded).
  task automatic wait_send(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (SEND_BYTE !== 1'b1 && cycles < 200);
  endtask

  task automatic check_pkt_out(input string name, input pkt_t exp);
    check({name, "_status"}, 32'(MOUSE_STATUS), 32'(exp.status));
    check({name, "_dx"},     32'(MOUSE_DX),     32'(exp.dx));
    check({name, "_dy"},     32'(MOUSE_DY),     32'(exp.dy));
  endtask

  // Scoreboard consumer: data is compared the cycle after the pulse, once
  // the published registers have loaded.
  always begin
    tick();
    if (SEND_INTERRUPT === 1'b1) begin
      irq_count++;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_interrupt: got pulse in state 0x%0h, expected none", MASTER_STATE);
      end else begin
        mon_pkt = sb_q.pop_front();
        tick();
        check_pkt_out("publish", mon_pkt);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic stay_ok;

    // Packet traffic, starting in PKT0.
    vecs[0]  = '{8'h08, 2'b00, PKT1,    1'b0, '0};
    vecs[1]  = '{8'h05, 2'b00, PKT2,    1'b0, '0};
    vecs[2]  = '{8'hFB, 2'b00, PUBLISH, 1'b1, pkt_t'{8'h08, 8'h05, 8'hFB}};
    vecs[3]  = '{8'h00, 2'b00, PKT0,    1'b0, '0};  // bit 3 clear: dropped
    vecs[4]  = '{8'h09, 2'b00, PKT1,    1'b0, '0};
    vecs[5]  = '{8'h01, 2'b00, PKT2,    1'b0, '0};
    vecs[6]  = '{8'h02, 2'b00, PUBLISH, 1'b1, pkt_t'{8'h09, 8'h01, 8'h02}};
    vecs[7]  = '{8'h18, 2'b00, PKT1,    1'b0, '0};
    vecs[8]  = '{8'h33, 2'b01, PKT0,    1'b0, '0};  // error in PKT1
    vecs[9]  = '{8'h08, 2'b00, PKT1,    1'b0, '0};
    vecs[10] = '{8'h07, 2'b00, PKT2,    1'b0, '0};
    vecs[11] = '{8'h55, 2'b10, PKT0,    1'b0, '0};  // error in PKT2
    vecs[12] = '{8'h0C, 2'b01, PKT0,    1'b0, '0};  // error in PKT0
    vecs[13] = '{8'h08, 2'b00, PKT1,    1'b0, '0};
    vecs[14] = '{8'h80, 2'b00, PKT2,    1'b0, '0};
    vecs[15] = '{8'h7F, 2'b00, PUBLISH, 1'b1, pkt_t'{8'h08, 8'h80, 8'h7F}};
    last_pkt = '0;

    // ---- Reset state
    repeat (3) tick();
    check("rst_state", 32'(MASTER_STATE), 32'(INIT));
    check("rst_send_byte", 32'(SEND_BYTE), 32'd0);
    check("rst_byte_to_send", 32'(BYTE_TO_SEND), 32'd0);
    check("rst_read_enable", 32'(READ_ENABLE), 32'd0);
    check("rst_interrupt", 32'(SEND_INTERRUPT), 32'd0);
    check_pkt_out("rst_out", '0);
    @(negedge CLK);
    RESET = 1'b0;

    // ---- Nominal bring-up: 0xFF request in the 11th cycle
    wait_send(n);
    check("init_wait_cycles", 32'(n), 32'd10);
    check("cmd_reset_byte", 32'(BYTE_TO_SEND), 32'hFF);
    check("read_enable_on", 32'(READ_ENABLE), 32'd1);

    // BYTE_SENT arriving in the very cycle the timeout expires must win.
    stay_ok = 1'b1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (i == 1) check("send_byte_one_cycle", 32'(SEND_BYTE), 32'd0);
      if (MASTER_STATE != WAIT_SENT_RST) stay_ok = 1'b0;
    end
    check("wait_sent_hold", 32'(stay_ok), 32'd1);
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
    check("sent_beats_timeout", 32'(MASTER_STATE), 32'(WAIT_ACK1));

    rx_byte(8'hFA, 2'b00);
    check("ack1_to_bat", 32'(MASTER_STATE), 32'(WAIT_BAT));
    rx_byte(8'hAA, 2'b00);
    check("bat_to_id", 32'(MASTER_STATE), 32'(WAIT_ID));
    rx_byte(8'h00, 2'b00);
    check("id_to_send_en", 32'(MASTER_STATE), 32'(SEND_EN));
    check("cmd_enable_strobe", 32'(SEND_BYTE), 32'd1);
    check("cmd_enable_byte", 32'(BYTE_TO_SEND), 32'hF4);
    tx_done(3);
    check("sent_en_to_ack2", 32'(MASTER_STATE), 32'(WAIT_ACK2));
    rx_byte(8'hFA, 2'b00);
    check("ack2_to_pkt0", 32'(MASTER_STATE), 32'(PKT0));

    // ---- Packet vectors
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].push) begin
        sb_q.push_back(vecs[i].pkt);
        n_pushed++;
      end
      rx_byte(vecs[i].data, vecs[i].err);
      check($sformatf("vec%0d_state", i), 32'(MASTER_STATE), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d_irq", i), 32'(SEND_INTERRUPT), 32'(vecs[i].exp_state == PUBLISH));
      if (vecs[i].push) last_pkt = vecs[i].pkt;
      repeat (2) tick();
      check($sformatf("vec%0d_settled", i), 32'(MASTER_STATE),
            32'((vecs[i].exp_state == PUBLISH) ? PKT0 : vecs[i].exp_state));
      check_pkt_out($sformatf("vec%0d_hold", i), last_pkt);
    end

    // ---- PKT1 timeout discards the partial packet
    rx_byte(8'h08, 2'b00);
    check("pkt1_entry", 32'(MASTER_STATE), 32'(PKT1));
    n = 0;
    while (MASTER_STATE == PKT1 && n < 1500) begin
      tick();
      n++;
    end
    check("pkt1_timeout_cycles", 32'(n), 32'd1000);
    check("pkt1_timeout_state", 32'(MASTER_STATE), 32'(PKT0));
    rx_byte(8'h05, 2'b00);  // would be dx; without a status byte it is dropped
    check("partial_discarded", 32'(MASTER_STATE), 32'(PKT0));
    check_pkt_out("timeout_hold", last_pkt);

    // ---- Reset in the middle of a packet
    rx_byte(8'h08, 2'b00);
    rx_byte(8'h05, 2'b00);
    check("pkt2_entry", 32'(MASTER_STATE), 32'(PKT2));
    #4;
    RESET = 1'b1;
    #1;
    check("midrst_state", 32'(MASTER_STATE), 32'(INIT));
    check("midrst_read_enable", 32'(READ_ENABLE), 32'd0);
    check("midrst_send_byte", 32'(SEND_BYTE), 32'd0);
    check_pkt_out("midrst_out", '0);
    last_pkt = '0;
    rx_byte(8'hFB, 2'b00);  // final byte arrives while held in reset
    check("midrst_no_irq", 32'(SEND_INTERRUPT), 32'd0);
    check("midrst_held", 32'(MASTER_STATE), 32'(INIT));
    @(negedge CLK);
    RESET = 1'b0;
    wait_send(n);
    check("restart_init_wait", 32'(n), 32'd10);

    // ---- No BYTE_SENT: timeout back to INIT; a byte received meanwhile is ignored
    n = 0;
    for (int i = 0; i < 1500; i++) begin
      tick();
      BYTE_READY = 1'b0;
      if (MASTER_STATE != WAIT_SENT_RST) break;
      n++;
      if (n == 5) begin
        BYTE_READ  = 8'hFA;
        BYTE_READY = 1'b1;
      end
    end
    check("sent_timeout_cycles", 32'(n), 32'd1000);
    check("sent_timeout_state", 32'(MASTER_STATE), 32'(INIT));
    check("sent_timeout_rd_en", 32'(READ_ENABLE), 32'd0);

    // ---- Bad acknowledge restarts the sequence
    wait_send(n);
    check("pre_badack_wait", 32'(n), 32'd10);
    tx_done(2);
    check("badack_entry", 32'(MASTER_STATE), 32'(WAIT_ACK1));
    rx_byte(8'hFE, 2'b00);
    check("badack_to_init", 32'(MASTER_STATE), 32'(INIT));
    wait_send(n);
    check("badack_resend_wait", 32'(n), 32'd10);
    check("badack_resend_byte", 32'(BYTE_TO_SEND), 32'hFF);

    repeat (5) tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("interrupt_count", 32'(irq_count), 32'(n_pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
